// File: rtl/tx_buf_pkg.sv
// Shared types and default sizing for the tx_word_buffer slice.
package tx_buf_pkg;

   localparam int TXBUF_WIDTH     = 16;
   localparam int TXBUF_DEPTH     = 8;
   localparam int TXBUF_FRAME_LEN = 4;

   // IDLE    | waiting for a stored word
   // SEND    | out_valid high for this single cycle
   // WAIT    | holding out_data until the transceiver reports done
   // CK_SEND | out_valid high for the frame checksum word
   // CK_WAIT | holding the checksum word until done
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      WAIT    = 3'd2,
      CK_SEND = 3'd3,
      CK_WAIT = 3'd4
   } tx_state_e;

endpackage

// File: rtl/tx_word_buffer_sync_fifo.sv
// Single-clock FIFO storage for tx_word_buffer. Pointers carry one extra
// wrap bit so full and empty are told apart by the MSB.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; requests are ignored when they cannot be honoured.
   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/tx_word_buffer.sv
// Elastic buffer between the core result port and the UART send port.
// Optional per-frame XOR checksum word is enabled by defining TXBUF_CKSUM_EN.
module tx_word_buffer
   import tx_buf_pkg::*;
#(
   parameter int WIDTH     = TXBUF_WIDTH,
   parameter int DEPTH     = TXBUF_DEPTH,
   parameter int FRAME_LEN = TXBUF_FRAME_LEN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     in_done,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_LEN < 1) begin : g_bad_cfg
      $error("tx_word_buffer: DEPTH must be a power of two >= 2 and FRAME_LEN >= 1");
   end

   tx_state_e        state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             in_done_q, in_done_d;
   logic             overflow_q, overflow_d;

   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rd_data;
   logic             fifo_full, fifo_empty;

`ifdef TXBUF_CKSUM_EN
   localparam int FCW = $clog2(FRAME_LEN + 1);
   logic [WIDTH-1:0] xor_q, xor_d;
   logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
`endif

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid),
      .wr_data (in_data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign in_ready  = !fifo_full;
   assign in_done   = in_done_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;

   // Write-side status: acknowledge accepted words, latch dropped ones.
   always_comb begin
      in_done_d  = in_valid && !fifo_full;
      overflow_d = overflow_q || (in_valid && fifo_full);
   end

   // Send sequencer; out_valid is registered on entry to a send state.
   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      fifo_rd_en  = 1'b0;
`ifdef TXBUF_CKSUM_EN
      xor_d       = xor_q;
      frame_cnt_d = frame_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_en  = 1'b1;
               out_data_d  = fifo_rd_data;
               out_valid_d = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: state_d = WAIT;
         WAIT: begin
            if (out_done) begin
`ifdef TXBUF_CKSUM_EN
               if (frame_cnt_q == FCW'(FRAME_LEN - 1)) begin
                  out_data_d  = xor_q ^ out_data_q;
                  out_valid_d = 1'b1;
                  xor_d       = '0;
                  frame_cnt_d = '0;
                  state_d     = CK_SEND;
               end else begin
                  xor_d       = xor_q ^ out_data_q;
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  state_d     = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef TXBUF_CKSUM_EN
         CK_SEND: state_d = CK_WAIT;
         CK_WAIT: begin
            if (out_done) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_done_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_done_q   <= in_done_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef TXBUF_CKSUM_EN
   // Running checksum and frame position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xor_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         xor_q       <= xor_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
`endif

endmodule
